// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
//   Writeback and operand stage around the 12-bit ALU. Holds an NREGS x DATA_W
//   register file and a 4-bit flags register {C,E,S,V}. Two combinational read
//   ports (write-first bypass) feed the ALU operands; flag C feeds ALU carry_in.
//   ALU results arrive on a valid/ready handshake and commit data and flags on
//   the transfer edge. An external write port (loads / debug) has priority and
//   stalls ALU writeback while asserted.
//
//   ALU func_code encoding used to decide whether C/V follow a result:
//     ADD=3'd0 SUB=3'd1 AND=3'd2 OR=3'd3 XOR=3'd4 NOT=3'd5
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid / wb_ready      ALU result handshake (ready = !rst && !ext_we)
//   wb_addr, wb_data         destination register and result data
//   wb_func, wb_flags_en     result opcode, flag update enable
//   wb_carry/equ/sign/ovf    ALU flag outputs for this result
//   ext_we/addr/data         priority external register write
//   clr_carry                clear flag C at the next edge
//   rd_a_addr/rd_a_data      operand A read port
//   rd_b_addr/rd_b_data      operand B read port
//   carry_fb                 registered flag C
//   flags                    {C,E,S,V}
//   wb_count                 committed ALU writebacks, mod 256
// -----------------------------------------------------------------------------
module alu_writeback #(
  parameter int DATA_W = 12,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        wb_func,
  input  logic              wb_flags_en,
  input  logic              wb_carry,
  input  logic              wb_equ,
  input  logic              wb_sign,
  input  logic              wb_ovf,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              clr_carry,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              carry_fb,
  output logic [3:0]        flags,
  output logic [7:0]        wb_count
);

  localparam logic [2:0] FUNC_ADD = 3'd0;
  localparam logic [2:0] FUNC_SUB = 3'd1;

  // Flag bit positions inside flags_q
  localparam int FC = 3;
  localparam int FE = 2;
  localparam int FS = 1;
  localparam int FV = 0;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [3:0]        flags_q, flags_d;
  logic [7:0]        count_q, count_d;

  logic              xfer;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign wb_ready = !rst && !ext_we;
  assign xfer     = wb_valid && wb_ready;

  // Single write port: the external write wins, the ALU result waits.
  // Gated by rst so the bypass never shows data that reset will discard.
  assign we      = !rst && (ext_we || wb_valid);
  assign wr_addr = ext_we ? ext_addr : wb_addr;
  assign wr_data = ext_we ? ext_data : wb_data;

  // Register file: every entry clears on reset, so it is built from flops.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        regs_q[gi] <= '0;
      end else if (we && (wr_addr == ADDR_W'(gi))) begin
        regs_q[gi] <= wr_data;
      end
    end
  end

  // Write-first bypass so an operand read in the commit cycle sees new data.
  assign rd_a_data = (we && (wr_addr == rd_a_addr)) ? wr_data : regs_q[rd_a_addr];
  assign rd_b_data = (we && (wr_addr == rd_b_addr)) ? wr_data : regs_q[rd_b_addr];

  always_comb begin
    flags_d = flags_q;
    if (xfer && wb_flags_en) begin
      flags_d[FE] = wb_equ;
      flags_d[FS] = wb_sign;
      // Carry and overflow only carry meaning for arithmetic results.
      if ((wb_func == FUNC_ADD) || (wb_func == FUNC_SUB)) begin
        flags_d[FC] = wb_carry;
        flags_d[FV] = wb_ovf;
      end
    end
    if (clr_carry) begin
      flags_d[FC] = 1'b0;
    end
  end

  assign count_d = xfer ? count_q + 8'd1 : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  assign flags    = flags_q;
  assign carry_fb = flags_q[FC];
  assign wb_count = count_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_XOR = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [11:0] wb_data;
  logic [2:0]  wb_func;
  logic        wb_flags_en;
  logic        wb_carry, wb_equ, wb_sign, wb_ovf;
  logic        ext_we;
  logic [2:0]  ext_addr;
  logic [11:0] ext_data;
  logic        clr_carry;
  logic [2:0]  rd_a_addr, rd_b_addr;
  logic [11:0] rd_a_data, rd_b_data;
  logic        carry_fb;
  logic [3:0]  flags;
  logic [7:0]  wb_count;

  alu_writeback dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_func(wb_func),
    .wb_flags_en(wb_flags_en), .wb_carry(wb_carry), .wb_equ(wb_equ),
    .wb_sign(wb_sign), .wb_ovf(wb_ovf),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .clr_carry(clr_carry),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .carry_fb(carry_fb), .flags(flags), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: architectural state only.
  int m_regs [8];
  bit m_c, m_e, m_s, m_v;
  int m_count;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Value a read port must show: this cycle's write to that address, else the stored value.
  function automatic int exp_rd(input logic [2:0] a);
    if (!rst && ext_we && ext_addr == a) return int'(ext_data);
    if (!rst && !ext_we && wb_valid && wb_addr == a) return int'(wb_data);
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      {m_c, m_e, m_s, m_v} = 4'b0;
      m_count = 0;
    end else begin
      if (ext_we) begin
        m_regs[ext_addr] = int'(ext_data);
      end else if (wb_valid) begin
        m_regs[wb_addr] = int'(wb_data);
        m_count = (m_count + 1) % 256;
        if (wb_flags_en) begin
          m_e = wb_equ;
          m_s = wb_sign;
          if (wb_func == F_ADD || wb_func == F_SUB) begin
            m_c = wb_carry;
            m_v = wb_ovf;
          end
        end
      end
      if (clr_carry) m_c = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_ready",  int'(wb_ready),  int'(!rst && !ext_we));
      check("rd_a_data", int'(rd_a_data), exp_rd(rd_a_addr));
      check("rd_b_data", int'(rd_b_data), exp_rd(rd_b_addr));
      check("flags",     int'(flags),     int'({m_c, m_e, m_s, m_v}));
      check("carry_fb",  int'(carry_fb),  int'(m_c));
      check("wb_count",  int'(wb_count),  m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [2:0] a, input logic [11:0] d, input logic [2:0] f,
                          input logic fen, input logic c, input logic e, input logic s,
                          input logic v);
    wb_valid = 1'b1; wb_addr = a; wb_data = d; wb_func = f; wb_flags_en = fen;
    wb_carry = c; wb_equ = e; wb_sign = s; wb_ovf = v;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_func = '0;
    wb_flags_en = 1'b0; wb_carry = 1'b0; wb_equ = 1'b0; wb_sign = 1'b0; wb_ovf = 1'b0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; clr_carry = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0;

    // 1 Reset for two cycles
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_flags", int'(flags), 0);
    check("rst_count", int'(wb_count), 0);
    check("rst_ready", int'(wb_ready), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_a_addr = 3'(i);
      #1;
      check("rst_reg_zero", int'(rd_a_data), 0);
    end

    // 2 ADD commit to r3 with carry
    step();
    drive_wb(3'd3, 12'h000, F_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    wb_valid = 1'b0; rd_a_addr = 3'd3;
    @(negedge clk);
    check("add_r3", int'(rd_a_data), 0);
    check("add_flags", int'(flags), 4'b1000);
    check("add_carry_fb", int'(carry_fb), 1);
    check("add_count", int'(wb_count), 1);

    // 3 Bypass on both ports
    step();
    drive_wb(3'd5, 12'hA5A, F_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_a_addr = 3'd5; rd_b_addr = 3'd5;
    @(negedge clk);
    check("bypass_a", int'(rd_a_data), 12'hA5A);
    check("bypass_b", int'(rd_b_data), 12'hA5A);
    step();
    wb_valid = 1'b0;

    // 4 Stall by external write to the same register
    ext_we = 1'b1; ext_addr = 3'd2; ext_data = 12'h123;
    drive_wb(3'd2, 12'h456, F_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_a_addr = 3'd2;
    @(negedge clk);
    check("stall_ready", int'(wb_ready), 0);
    check("stall_ext_bypass", int'(rd_a_data), 12'h123);
    step();
    ext_we = 1'b0;
    @(negedge clk);
    check("stall_release_ready", int'(wb_ready), 1);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("stall_r2", int'(rd_a_data), 12'h456);
    check("stall_count", int'(wb_count), 3);

    // 5 Logic op holds C/V, clr_carry clears C
    step();
    drive_wb(3'd1, 12'h800, F_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive_wb(3'd1, 12'hF0F, F_XOR, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("xor_flags", int'(flags), 4'b1011);
    step();
    clr_carry = 1'b1;
    step();
    clr_carry = 1'b0;
    @(negedge clk);
    check("clr_flags", int'(flags), 4'b0011);
    // clr_carry overriding a concurrent ADD carry; E/S/V still update
    step();
    drive_wb(3'd4, 12'h000, F_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    clr_carry = 1'b1;
    step();
    wb_valid = 1'b0; clr_carry = 1'b0;
    @(negedge clk);
    check("clr_vs_add_flags", int'(flags), 4'b0100);
    check("count_6", int'(wb_count), 6);

    // 6 Wrap: 250 transfers bring the count from 6 to 0, 6 more to 6
    step();
    for (int i = 0; i < 256; i++) begin
      drive_wb(3'($urandom_range(7)), 12'($urandom), 3'($urandom_range(5)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      rd_a_addr = 3'($urandom_range(7));
      rd_b_addr = 3'($urandom_range(7));
      step();
      if (i == 249) begin
        @(negedge clk);
        check("wrap_zero", int'(wb_count), 0);
      end
    end
    wb_valid = 1'b0;
    @(negedge clk);
    check("wrap_full", int'(wb_count), 6);

    // Reset during a stalled writeback discards the result
    step();
    ext_we = 1'b1; ext_addr = 3'd0; ext_data = 12'h777;
    drive_wb(3'd7, 12'hFFF, F_ADD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; ext_we = 1'b0; wb_valid = 1'b0;
    rd_a_addr = 3'd7; rd_b_addr = 3'd0;
    @(negedge clk);
    check("rst_stall_r7", int'(rd_a_data), 0);
    check("rst_stall_r0", int'(rd_b_data), 0);
    check("rst_stall_count", int'(wb_count), 0);
    check("rst_stall_flags", int'(flags), 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
